// File: rtl/axi_burst_bridge.sv
// -----------------------------------------------------------------------------
// axi_burst_bridge
//
// Connects an instruction cache and a data cache to one AXI3 master port.
// The two caches compete for the port, and round-robin arbitration decides
// which one is served. Only one transaction is outstanding at any time.
//
// Transactions:
//   icache miss         -> line read burst (LINE_WORDS beats, INCR, 32-bit)
//   dcache op 00 cached -> line read burst
//   dcache op 00 uncached (and the unused op 11) -> single read, size from sel
//   dcache op 01        -> single write, wstrb = sel, wdata = dc_wdata
//   dcache op 10        -> line writeback, data read from dc_wb_data/dc_wb_idx
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ic_*                icache request / refill-write / done+err
//   dc_*                dcache request / line-buffer read / read-write / done+err
//   ar*, r*, aw*, w*, b* AXI3 master channels (ID = IC_ID or DC_ID)
//
// Every output comes from a register. A requester must hold req until it
// sees its done pulse. err is valid together with done. err stays set until
// the next grant to that requester.
// -----------------------------------------------------------------------------
module axi_burst_bridge #(
    parameter int         LINE_WORDS = 16,
    parameter logic [3:0] IC_ID      = 4'b0000,
    parameter logic [3:0] DC_ID      = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    // icache side
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_we,
    output logic [31:0] ic_waddr,
    output logic [31:0] ic_wdata,
    output logic        ic_done,
    output logic        ic_err,
    // dcache side
    input  logic        dc_req,
    input  logic [1:0]  dc_op,
    input  logic [31:0] dc_addr,
    input  logic [3:0]  dc_sel,
    input  logic        dc_cached,
    input  logic [31:0] dc_wdata,
    output logic [3:0]  dc_wb_idx,
    input  logic [31:0] dc_wb_data,
    output logic        dc_we,
    output logic [31:0] dc_waddr,
    output logic [31:0] dc_rdata,
    output logic        dc_done,
    output logic        dc_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int          OFF_BITS  = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_dc_q, owner_dc_d;   // 1: dcache owns the transaction
    logic        last_dc_q, last_dc_d;     // round-robin: last grant went to dcache
    logic        line_q, line_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic        err_acc_q, err_acc_d;
    logic [4:0]  beat_q, beat_d;           // 5 bits so an over-long read burst is still counted
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        rready_q, rready_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wlast_q, wlast_d;
    logic        bready_q, bready_d;
    logic [3:0]  wb_idx_q, wb_idx_d;
    logic        ic_we_q, ic_we_d;
    logic        dc_we_q, dc_we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ic_done_q, ic_done_d;
    logic        dc_done_q, dc_done_d;
    logic        ic_err_q, ic_err_d;
    logic        dc_err_q, dc_err_d;

    // Temporaries for the next-state logic
    logic        grant_ic, grant_dc, is_line, is_write, finish, err_now;
    logic [31:0] req_addr;

    // The bridge does not check IDs, because only one transaction is in flight.
    logic unused_ids;
    assign unused_ids = ^{rid, bid};

    function automatic logic [2:0] size_from_sel(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_from_sel = 3'b000;
            4'b0011, 4'b1100:                   size_from_sel = 3'b001;
            default:                            size_from_sel = 3'b010;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        owner_dc_d   = owner_dc_q;
        last_dc_d    = last_dc_q;
        line_d       = line_q;
        hold_wdata_d = hold_wdata_q;
        err_acc_d    = err_acc_q;
        beat_d       = beat_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        strb_d       = strb_q;
        arvalid_d    = arvalid_q;
        awvalid_d    = awvalid_q;
        rready_d     = rready_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        wlast_d      = wlast_q;
        bready_d     = bready_q;
        wb_idx_d     = wb_idx_q;
        ic_we_d      = 1'b0;
        dc_we_d      = 1'b0;
        waddr_d      = waddr_q;
        rdata_d      = rdata_q;
        ic_done_d    = 1'b0;
        dc_done_d    = 1'b0;
        ic_err_d     = ic_err_q;
        dc_err_d     = dc_err_q;
        grant_ic     = 1'b0;
        grant_dc     = 1'b0;
        is_line      = 1'b0;
        is_write     = 1'b0;
        finish       = 1'b0;
        err_now      = err_acc_q;
        req_addr     = 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                grant_ic = ic_req && (!dc_req || last_dc_q);
                grant_dc = dc_req && !grant_ic;
                if (grant_ic || grant_dc) begin
                    owner_dc_d   = grant_dc;
                    last_dc_d    = grant_dc;
                    err_acc_d    = 1'b0;
                    if (grant_dc) dc_err_d = 1'b0;
                    else          ic_err_d = 1'b0;
                    id_d         = grant_dc ? DC_ID : IC_ID;
                    is_write     = grant_dc && (dc_op == 2'b01 || dc_op == 2'b10);
                    is_line      = grant_ic || dc_op == 2'b10 || (dc_op == 2'b00 && dc_cached);
                    req_addr     = grant_dc ? dc_addr : ic_addr;
                    line_d       = is_line;
                    hold_wdata_d = dc_wdata;
                    beat_d       = 5'd0;
                    wb_idx_d     = 4'd0;
                    if (is_line) begin
                        addr_d = req_addr & LINE_MASK;
                        len_d  = LINE_LEN;
                        size_d = 3'b010;
                        strb_d = 4'b1111;
                    end else begin
                        addr_d = req_addr;
                        len_d  = 4'd0;
                        size_d = size_from_sel(dc_sel);
                        strb_d = dc_sel;
                    end
                    if (is_write) begin
                        awvalid_d = 1'b1;
                        state_d   = ST_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end

            ST_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end

            ST_R: begin
                if (rvalid) begin
                    if (owner_dc_q) dc_we_d = 1'b1;
                    else            ic_we_d = 1'b1;
                    waddr_d = addr_q + (32'(beat_q) << 2);
                    rdata_d = rdata;
                    beat_d  = beat_q + 5'd1;
                    err_now = err_acc_q || (rresp != 2'b00);
                    if (rlast) begin
                        // The last beat must be beat number len (counting from 0).
                        err_now  = err_now || (beat_q != {1'b0, len_q});
                        rready_d = 1'b0;
                        finish   = 1'b1;
                    end
                    err_acc_d = err_now;
                end
            end

            ST_AW: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    // dc_wb_idx is 0 here, so dc_wb_data already holds word 0.
                    // From now on the index runs one word ahead of beat, so the
                    // data register is always loaded from the next word.
                    wdata_d   = line_q ? dc_wb_data : hold_wdata_q;
                    wb_idx_d  = wb_idx_q + 4'd1;
                    wlast_d   = (len_q == 4'd0);
                    state_d   = ST_W;
                end
            end

            ST_W: begin
                if (wready) begin
                    if (beat_q == {1'b0, len_q}) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        beat_d   = beat_q + 5'd1;
                        wdata_d  = line_q ? dc_wb_data : hold_wdata_q;
                        wb_idx_d = wb_idx_q + 4'd1;
                        wlast_d  = ((beat_q + 5'd1) == {1'b0, len_q});
                    end
                end
            end

            ST_B: begin
                if (bvalid) begin
                    bready_d  = 1'b0;
                    err_now   = err_acc_q || (bresp != 2'b00);
                    err_acc_d = err_now;
                    finish    = 1'b1;
                end
            end

            ST_DONE: begin
                beat_d   = 5'd0;
                wb_idx_d = 4'd0;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // done and err are loaded on the way into DONE, so the pulse lines up
        // with the single DONE cycle.
        if (finish) begin
            state_d = ST_DONE;
            if (owner_dc_q) begin
                dc_done_d = 1'b1;
                dc_err_d  = err_now;
            end else begin
                ic_done_d = 1'b1;
                ic_err_d  = err_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_dc_q   <= 1'b0;
            last_dc_q    <= 1'b1;
            line_q       <= 1'b0;
            hold_wdata_q <= 32'd0;
            err_acc_q    <= 1'b0;
            beat_q       <= 5'd0;
            id_q         <= 4'd0;
            addr_q       <= 32'd0;
            len_q        <= 4'd0;
            size_q       <= 3'd0;
            strb_q       <= 4'd0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            wvalid_q     <= 1'b0;
            wdata_q      <= 32'd0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            wb_idx_q     <= 4'd0;
            ic_we_q      <= 1'b0;
            dc_we_q      <= 1'b0;
            waddr_q      <= 32'd0;
            rdata_q      <= 32'd0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
            ic_err_q     <= 1'b0;
            dc_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_dc_q   <= owner_dc_d;
            last_dc_q    <= last_dc_d;
            line_q       <= line_d;
            hold_wdata_q <= hold_wdata_d;
            err_acc_q    <= err_acc_d;
            beat_q       <= beat_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            strb_q       <= strb_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            rready_q     <= rready_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            wb_idx_q     <= wb_idx_d;
            ic_we_q      <= ic_we_d;
            dc_we_q      <= dc_we_d;
            waddr_q      <= waddr_d;
            rdata_q      <= rdata_d;
            ic_done_q    <= ic_done_d;
            dc_done_q    <= dc_done_d;
            ic_err_q     <= ic_err_d;
            dc_err_q     <= dc_err_d;
        end
    end

    // Read and write share one set of address and attribute registers,
    // because only one transaction exists at a time.
    assign arid      = id_q;
    assign awid      = id_q;
    assign wid       = id_q;
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arlen     = len_q;
    assign awlen     = len_q;
    assign arsize    = size_q;
    assign awsize    = size_q;
    assign arburst   = 2'b01;
    assign awburst   = 2'b01;
    assign arlock    = 2'b00;
    assign awlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign awcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign awprot    = 3'b000;
    assign arvalid   = arvalid_q;
    assign awvalid   = awvalid_q;
    assign rready    = rready_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = strb_q;
    assign wlast     = wlast_q;
    assign bready    = bready_q;
    assign dc_wb_idx = wb_idx_q;
    assign ic_we     = ic_we_q;
    assign dc_we     = dc_we_q;
    assign ic_waddr  = waddr_q;
    assign dc_waddr  = waddr_q;
    assign ic_wdata  = rdata_q;
    assign dc_rdata  = rdata_q;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign ic_err    = ic_err_q;
    assign dc_err    = dc_err_q;

endmodule

// File: tb/tb_axi_burst_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_bridge
//
// Bench for axi_burst_bridge. It behaves as the AXI slave and as both cache
// requesters. When the bench drives a read beat, it pushes the expected
// refill write to a queue. When the bench starts a write, it pushes the
// expected W beats to a queue. A monitor pops the refill queue on every
// ic_we/dc_we pulse. The write-slave task pops the W queue on every
// handshake.
// -----------------------------------------------------------------------------
module tb_axi_burst_bridge;

    localparam logic [3:0] IC_ID = 4'h0;
    localparam logic [3:0] DC_ID = 4'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_we;
    logic [31:0] ic_waddr, ic_wdata;
    logic        ic_done, ic_err;
    logic        dc_req;
    logic [1:0]  dc_op;
    logic [31:0] dc_addr;
    logic [3:0]  dc_sel;
    logic        dc_cached;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wb_idx;
    logic [31:0] dc_wb_data;
    logic        dc_we;
    logic [31:0] dc_waddr, dc_rdata;
    logic        dc_done, dc_err;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    axi_burst_bridge #(.LINE_WORDS(16), .IC_ID(IC_ID), .DC_ID(DC_ID)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_we(ic_we), .ic_waddr(ic_waddr),
        .ic_wdata(ic_wdata), .ic_done(ic_done), .ic_err(ic_err),
        .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_sel(dc_sel),
        .dc_cached(dc_cached), .dc_wdata(dc_wdata), .dc_wb_idx(dc_wb_idx),
        .dc_wb_data(dc_wb_data), .dc_we(dc_we), .dc_waddr(dc_waddr),
        .dc_rdata(dc_rdata), .dc_done(dc_done), .dc_err(dc_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // dcache line buffer model: combinational read at dc_wb_idx
    logic [31:0] wb_line [16];
    assign dc_wb_data = wb_line[dc_wb_idx];

    typedef struct {
        bit          is_ic;
        logic [31:0] addr;
        logic [31:0] data;
    } we_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        bit          last;
    } w_exp_t;

    we_exp_t we_q[$];
    w_exp_t  w_q[$];
    we_exp_t mon_e;

    int vec_cnt     = 0;
    int miscmp_cnt  = 0;
    int ic_done_cnt = 0;
    int dc_done_cnt = 0;
    int ic_we_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Refill-write monitor: each ic_we/dc_we pulse must match the oldest expected beat.
    always @(negedge clk) begin
        if (ic_we) ic_we_cnt++;
        if (ic_done) ic_done_cnt++;
        if (dc_done) dc_done_cnt++;
        if (ic_we || dc_we) begin
            if (we_q.size() == 0) begin
                check_eq("we_unexpected", 32'(we_q.size()), 32'd1);
            end else begin
                mon_e = we_q.pop_front();
                check_eq("we_owner", 32'(ic_we), 32'(mon_e.is_ic));
                check_eq("we_single", 32'(ic_we && dc_we), 32'd0);
                check_eq("waddr", mon_e.is_ic ? ic_waddr : dc_waddr, mon_e.addr);
                check_eq("wrdata", mon_e.is_ic ? ic_wdata : dc_rdata, mon_e.data);
            end
        end
    end

    task automatic wait_done(input bit is_ic, input bit exp_err);
        int n;
        n = 0;
        while (!(is_ic ? ic_done : dc_done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(is_ic ? "ic_done" : "dc_done", 32'(is_ic ? ic_done : dc_done), 32'd1);
        check_eq(is_ic ? "ic_err" : "dc_err", 32'(is_ic ? ic_err : dc_err), 32'(exp_err));
        check_eq("other_done", 32'(is_ic ? dc_done : ic_done), 32'd0);
        $display("txn %s done err=%0d", is_ic ? "icache" : "dcache", is_ic ? ic_err : dc_err);
        if (is_ic) ic_req = 1'b0;
        else       dc_req = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", 32'(is_ic ? ic_done : dc_done), 32'd0);
    endtask

    task automatic serve_read(input bit is_ic, input logic [31:0] exp_addr, input logic [3:0] exp_len,
                              input logic [2:0] exp_size, input int n_beats, input logic [1:0] last_resp,
                              input bit exp_err, output int ar_wait);
        int      n;
        we_exp_t e;
        n = 0;
        while (!arvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ar_wait = n;
        check_eq("arvalid", 32'(arvalid), 32'd1);
        check_eq("araddr", araddr, exp_addr);
        check_eq("arlen", 32'(arlen), 32'(exp_len));
        check_eq("arsize", 32'(arsize), 32'(exp_size));
        check_eq("arid", 32'(arid), is_ic ? 32'(IC_ID) : 32'(DC_ID));
        check_eq("ar_const", 32'({arburst, arlock, arcache, arprot}), 32'h200);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_eq("ar_drop", 32'(arvalid), 32'd0);
        check_eq("rready_up", 32'(rready), 32'd1);
        for (int i = 0; i < n_beats; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rvalid = 1'b1;
            rdata  = $urandom;
            rresp  = (i == n_beats - 1) ? last_resp : 2'b00;
            rlast  = (i == n_beats - 1);
            rid    = is_ic ? IC_ID : DC_ID;
            e.is_ic = is_ic;
            e.addr  = exp_addr + 32'(4 * i);
            e.data  = rdata;
            we_q.push_back(e);
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        check_eq("rready_drop", 32'(rready), 32'd0);
        wait_done(is_ic, exp_err);
    endtask

    task automatic serve_write(input logic [31:0] exp_addr, input logic [3:0] exp_len,
                               input logic [2:0] exp_size, input int n_beats, input logic [1:0] resp,
                               input bit exp_err, input bit rand_ready);
        int     n;
        int     beats;
        w_exp_t e;
        n = 0;
        while (!awvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("awvalid", 32'(awvalid), 32'd1);
        check_eq("awaddr", awaddr, exp_addr);
        check_eq("awlen", 32'(awlen), 32'(exp_len));
        check_eq("awsize", 32'(awsize), 32'(exp_size));
        check_eq("awid", 32'(awid), 32'(DC_ID));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_eq("aw_hold", 32'(awvalid), 32'd1);
        check_eq("w_before_aw", 32'(wvalid), 32'd0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check_eq("aw_drop", 32'(awvalid), 32'd0);
        beats = 0;
        n     = 0;
        while (beats < n_beats && n < 300) begin
            wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid && wready) begin
                if (w_q.size() == 0) begin
                    check_eq("w_unexpected", 32'(w_q.size()), 32'd1);
                end else begin
                    e = w_q.pop_front();
                    check_eq("wdata", wdata, e.data);
                    check_eq("wstrb", 32'(wstrb), 32'(e.strb));
                    check_eq("wlast", 32'(wlast), 32'(e.last));
                    check_eq("wid", 32'(wid), 32'(DC_ID));
                end
                beats++;
            end
            @(negedge clk);
            n++;
        end
        wready = 1'b0;
        check_eq("w_beats", 32'(beats), 32'(n_beats));
        n = 0;
        while (!bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("bready", 32'(bready), 32'd1);
        check_eq("w_idle", 32'(wvalid), 32'd0);
        bvalid = 1'b1;
        bresp  = resp;
        bid    = DC_ID;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        check_eq("bready_drop", 32'(bready), 32'd0);
        wait_done(1'b0, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int     wt;
        int     saved;
        w_exp_t we;
        we_exp_t re;

        rst = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_op = 2'b00; dc_addr = '0; dc_sel = 4'h0; dc_cached = 1'b0; dc_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        for (int i = 0; i < 16; i++) wb_line[i] = $urandom;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", 32'(arvalid), 32'd0);
        check_eq("rst_awvalid", 32'(awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(wvalid), 32'd0);
        check_eq("rst_readys", 32'({rready, bready}), 32'd0);
        check_eq("rst_done_err", 32'({ic_done, dc_done, ic_err, dc_err}), 32'd0);
        check_eq("rst_we", 32'({ic_we, dc_we}), 32'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("rst_wb_idx", 32'(dc_wb_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: icache first (line 0x1FC00044), then dcache cached line read
        $display("txn tie: icache line 0x1FC00044 vs dcache line 0x00002234");
        ic_req = 1'b1; ic_addr = 32'h1FC0_0044;
        dc_req = 1'b1; dc_op = 2'b00; dc_cached = 1'b1; dc_addr = 32'h0000_2234; dc_sel = 4'hF;
        ic_we_cnt = 0;
        serve_read(1'b1, 32'h1FC0_0040, 4'd15, 3'b010, 16, 2'b00, 1'b0, wt);
        check_eq("ic_we_count", 32'(ic_we_cnt), 32'd16);
        serve_read(1'b0, 32'h0000_2200, 4'd15, 3'b010, 16, 2'b00, 1'b0, wt);
        check_eq("rr_gap_dc", 32'(wt), 32'd1);

        // Single halfword write
        $display("txn dcache single write 0xBFAF8002 sel 1100");
        dc_req = 1'b1; dc_op = 2'b01; dc_addr = 32'hBFAF_8002; dc_sel = 4'b1100; dc_wdata = 32'hDEAD_BEEF;
        we.data = 32'hDEAD_BEEF; we.strb = 4'b1100; we.last = 1'b1;
        w_q.push_back(we);
        serve_write(32'hBFAF_8002, 4'd0, 3'b001, 1, 2'b00, 1'b0, 1'b0);

        // Line writeback with random wready
        $display("txn dcache writeback 0x00001230");
        dc_req = 1'b1; dc_op = 2'b10; dc_addr = 32'h0000_1230; dc_sel = 4'hF;
        for (int k = 0; k < 16; k++) begin
            we.data = wb_line[k]; we.strb = 4'b1111; we.last = (k == 15);
            w_q.push_back(we);
        end
        serve_write(32'h0000_1200, 4'd15, 3'b010, 16, 2'b00, 1'b0, 1'b1);

        // icache alone, so the last grant goes to icache
        $display("txn icache line 0x00000310");
        ic_req = 1'b1; ic_addr = 32'h0000_0310;
        serve_read(1'b1, 32'h0000_0300, 4'd15, 3'b010, 16, 2'b00, 1'b0, wt);

        // Tie with last = icache: dcache uncached byte read with SLVERR wins, then icache
        $display("txn tie: dcache uncached 0x80000006 (rresp 10) vs icache 0x10000004");
        ic_req = 1'b1; ic_addr = 32'h1000_0004;
        dc_req = 1'b1; dc_op = 2'b00; dc_cached = 1'b0; dc_addr = 32'h8000_0006; dc_sel = 4'b0010;
        serve_read(1'b0, 32'h8000_0006, 4'd0, 3'b000, 1, 2'b10, 1'b1, wt);
        serve_read(1'b1, 32'h1000_0000, 4'd15, 3'b010, 16, 2'b00, 1'b0, wt);
        check_eq("rr_gap_ic", 32'(wt), 32'd1);

        // Short burst: rlast after 4 of 16 beats must flag an error
        $display("txn dcache line 0x00004000 with early rlast");
        dc_req = 1'b1; dc_op = 2'b00; dc_cached = 1'b1; dc_addr = 32'h0000_4000; dc_sel = 4'hF;
        serve_read(1'b0, 32'h0000_4000, 4'd15, 3'b010, 4, 2'b00, 1'b1, wt);

        // Reset in the middle of an R burst
        $display("txn icache line 0x00000500 aborted by reset");
        ic_req = 1'b1; ic_addr = 32'h0000_0500;
        wt = 0;
        while (!arvalid && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check_eq("abort_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = $urandom; rresp = 2'b00; rlast = 1'b0; rid = IC_ID;
            re.is_ic = 1'b1; re.addr = 32'h0000_0500 + 32'(4 * i); re.data = rdata;
            we_q.push_back(re);
            @(negedge clk);
            rvalid = 1'b0;
        end
        check_eq("abort_rready_before", 32'(rready), 32'd1);
        saved = ic_done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_rready", 32'(rready), 32'd0);
        check_eq("abort_arvalid_low", 32'(arvalid), 32'd0);
        ic_req = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_no_done", 32'(ic_done_cnt), 32'(saved));

        check_eq("we_q_empty", 32'(we_q.size()), 32'd0);
        check_eq("w_q_empty", 32'(w_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/axi_burst_bridge.md
AXI_BURST_BRIDGE -- requirements
Module: axi_burst_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16; words per cache line; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter IC_ID, default 4'b0000; AXI ID used for icache traffic.
REQ-003 SHALL have parameter DC_ID, default 4'b0001; AXI ID used for dcache traffic.
REQ-004 SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_req  in  1  icache miss request
- ic_addr  in  32  icache miss address
- ic_we  out  1  refill word write strobe to icache
- ic_waddr  out  32  refill word address
- ic_wdata  out  32  refill word data
- ic_done  out  1  icache transaction complete (pulse)
- ic_err  out  1  icache transaction error (valid with ic_done)
- dc_req  in  1  dcache request
- dc_op  in  2  dcache operation: 00 read, 01 single write, 10 line writeback
- dc_addr  in  32  dcache address
- dc_sel  in  4  dcache byte select
- dc_cached  in  1  1 = line read, 0 = uncached single read
- dc_wdata  in  32  single-write data
- dc_wb_idx  out  4  writeback word index to dcache line buffer
- dc_wb_data  in  32  line word at dc_wb_idx (combinational)
- dc_we  out  1  read word write strobe to dcache
- dc_waddr  out  32  read word address
- dc_rdata  out  32  read word data
- dc_done  out  1  dcache transaction complete (pulse)
- dc_err  out  1  dcache transaction error (valid with dc_done)
- AR channel  out  arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1; arready in 1
- R channel  in  rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; rready out 1
- AW channel  out  awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1; awready in 1
- W channel  out  wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1; wready in 1
- B channel  in  bid 4, bresp 2, bvalid 1; bready out 1

Function
REQ-006 SHALL implement states IDLE, AR, R, AW, W, B, DONE; all outputs registered.
REQ-007 Arbitration, in IDLE: a single request is granted; on simultaneous ic_req and dc_req, the requester not granted last wins (round-robin); after reset icache is treated as last-granted = dcache, so icache wins the first tie.
REQ-008 SHALL latch addr, op, sel and cached at grant; requesters hold req until done.
REQ-009 Line transfers:
- align address: low log2(LINE_WORDS)+2 bits cleared
- len = LINE_WORDS-1, size 3'b010, burst 2'b01, wstrb 4'b1111
REQ-010 Single transfers:
- address unaligned
- len 0
- size from sel: one-hot -> 000; 0011/1100 -> 001; any other -> 010
- wstrb = sel
REQ-011 Constant fields: lock 00, cache 0000, prot 000; arid/awid/wid = requester ID.
REQ-012 AR state: hold arvalid until arready, then go to R with rready = 1.
REQ-013 R state:
- each rvalid beat pulses ic_we or dc_we for one cycle; waddr = base + 4*beat; beat counter increments
- rlast ends the burst: rready drops, go to DONE
REQ-014 AW state: hold awvalid until awready, then go to W. W starts only after AW is accepted.
REQ-015 W state:
- wdata = dc_wb_data at dc_wb_idx = beat (writeback) or latched dc_wdata (single)
- beat advances on wvalid & wready
- wlast = 1 when beat == len
- after the last beat, go to B with bready = 1
REQ-016 B state: on bvalid, drop bready and go to DONE.
REQ-017 DONE: pulse the owner's done for exactly 1 cycle, clear counters, return to IDLE; no grant in the DONE cycle.
REQ-018 err SHALL be set if any rresp/bresp != 00 or if the rlast beat count != len+1; err clears at the next grant.
REQ-019 dcache read with dc_cached = 0 and icache requests never issue AW/W.

Reset
REQ-020 On rst:
- all valid/ready/strobe/done/err outputs = 0, addresses/data = 0, counters = 0
- state = IDLE, round-robin pointer = dcache
REQ-021 rst mid-transaction SHALL abort without a done pulse; valid/ready outputs drop on the next clock edge.

Verification
REQ-022 ic_req, ic_addr = 0x1FC0_0044, LINE_WORDS = 16 -> araddr 0x1FC0_0040, arlen 15; 16 ic_we pulses, waddr 0x1FC0_0040..0x1FC0_007C; one ic_done.
REQ-023 ic_req and dc_req (op 00) rise together after reset -> icache served first; then dcache served with no intervening idle cycle beyond DONE.
REQ-024 dc_op 01, addr 0xBFAF_8002, sel 1100 -> awlen 0, awsize 001, wstrb 1100, one beat with wlast = 1; dc_done after bvalid.
REQ-025 dc_op 10, addr 0x0000_1230 -> awaddr 0x0000_1200, 16 beats wdata = dc_wb_data[0..15]; wlast only on beat 15; wready toggled randomly, no beat lost.
REQ-026 Uncached read returns rresp 10 -> dc_err = 1 with dc_done; rst asserted during an R burst -> rready = 0 next cycle, no done pulse.
